fpu_uart_rx: RTL and testbench

- Upstream front-end for the bfloat16 FPU FSM.
- Deserialises the 8N1 UART line (pad or logic-analyser override, selected in the wrapper) into bytes.
- Pairs consecutive bytes into 16-bit operand/instruction words.
- Presents each word to the FPU FSM over a valid/ready handshake with a one-word holding register.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/fpu_uart_pkg.sv | 16 +
 rtl/uart_rx_byte.sv | 106 ++++++++++
 rtl/fpu_uart_rx.sv | 68 ++++++
 tb/tb_fpu_uart_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_uart_pkg.sv
// fpu_uart_pkg: shared types and widths for the FPU UART front-end.
// Imported by the byte receiver and the word assembler.
package fpu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchroniser and mid-bit sampling.
// Emits one byte per good frame; a low stop bit parks in BREAK until idle.
module uart_rx_byte
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [BYTE_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t         state;
    logic [1:0]        sync;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [BYTE_W-1:0] shift;
    logic              rxs;

    assign rxs  = sync[1];
    assign data = shift;

    // Combinational so the assembler captures the byte on the stop-sample edge.
    assign valid = (state == STOP) && (cnt == LAST) && rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync      <= {sync[0], rx};
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shift <= {rxs, shift[BYTE_W-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= BREAK;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fpu_uart_rx.sv
// fpu_uart_rx: pairs received bytes into 16-bit words for the FPU FSM.
// One-word holding register behind a valid/ready handshake; drops on overrun.
module fpu_uart_rx
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    logic [BYTE_W-1:0] rx_byte;
    logic [BYTE_W-1:0] hi;
    logic              byte_valid;
    logic              ptr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx_i),
        .data     (rx_byte),
        .valid    (byte_valid),
        .frame_err(frame_err_o),
        .busy     (busy_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi           <= '0;
            ptr          <= 1'b0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (word_valid_o && word_ready_i) word_valid_o <= 1'b0;
            if (byte_valid) begin
                if (!ptr) begin
                    hi  <= rx_byte;
                    ptr <= 1'b1;
                end else begin
                    ptr <= 1'b0;
                    if (!word_valid_o || word_ready_i) begin
                        word_o       <= {hi, rx_byte};
                        word_valid_o <= 1'b1;
                    end else begin
                        overrun_o <= 1'b1;
                    end
                end
            end else if (frame_err_o) begin
                // A bad frame leaves byte alignment unknown; restart on a high byte.
                ptr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_uart_rx.sv
// tb_fpu_uart_rx: directed and randomized frames against a byte-pairing model.
// Inputs change on the falling edge; the monitor samples 2 ns after it.
module tb_fpu_uart_rx;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_i = 1'b1;
    logic        word_ready_i = 1'b0;
    logic [15:0] word_o;
    logic        word_valid_o;
    logic        frame_err_o;
    logic        overrun_o;
    logic        busy_o;

    int          vectors = 0;
    int          miscompares = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          v_cnt = 0;
    logic [15:0] got[$];
    logic [7:0]  rb[$];
    logic        v78;
    logic        v79;

    always #5 clk = ~clk;

    fpu_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .word_o      (word_o),
        .word_valid_o(word_valid_o),
        .word_ready_i(word_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (word_valid_o && word_ready_i) got.push_back(word_o);
            if (word_valid_o) v_cnt++;
            if (frame_err_o) fe_cnt++;
            if (overrun_o) ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] first_word();
        return (got.size() > 0) ? got[0] : 16'hxxxx;
    endfunction

    // One 10-bit frame, one bit per CPB falling edges; optional ready/reset pulses.
    task automatic drive_frame(input logic [7:0] b, input logic stop,
                               input int len, input int ready_at,
                               input int rst_at, output logic s78,
                               output logic s79);
        logic [9:0] f;
        f   = {stop, b, 1'b0};
        s78 = 1'b0;
        s79 = 1'b0;
        for (int t = 0; t < len; t++) begin
            rx_i = f[t / CPB];
            if (t == ready_at) word_ready_i = 1'b1;
            else if (ready_at >= 0 && t == ready_at + 1) word_ready_i = 1'b0;
            rst = (t == rst_at);
            if (t == 78) s78 = word_valid_o;
            if (t == 79) s79 = word_valid_o;
            @(negedge clk);
        end
        rx_i = 1'b1;
        rst  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        logic a, c;
        drive_frame(b, 1'b1, 80, -1, -1, a, c);
        idle(2);
    endtask

    initial begin
        // Reset
        rst  = 1'b1;
        rx_i = 1'b1;
        idle(3);
        #3;
        check("rst_word", word_o, 16'h0000);
        check("rst_valid", word_valid_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_ovr", overrun_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst = 1'b0;
        idle(2);
        check("post_rst_busy", busy_o, 1'b0);

        // Normal word with latency check on the second frame
        word_ready_i = 1'b1;
        got.delete();
        v_cnt = 0;
        send(8'h3F);
        drive_frame(8'h80, 1'b1, 80, -1, -1, v78, v79);
        idle(4);
        check("lat_before", v78, 1'b0);
        check("lat_rise", v79, 1'b1);
        check("norm_count", got.size(), 1);
        check("norm_word", first_word(), 16'h3F80);
        check("norm_vcycles", v_cnt, 1);
        check("norm_ferr", fe_cnt, 0);
        check("norm_ovr", ov_cnt, 0);

        // Start-bit glitch
        got.delete();
        rx_i = 1'b0;
        idle(3);
        rx_i = 1'b1;
        idle(12);
        check("glitch_busy", busy_o, 1'b0);
        check("glitch_nobyte", got.size(), 0);
        send(8'h40);
        send(8'h49);
        idle(3);
        check("glitch_count", got.size(), 1);
        check("glitch_word", first_word(), 16'h4049);

        // Framing error after a lone good byte: pointer must resync
        got.delete();
        fe_cnt = 0;
        send(8'hAA);
        drive_frame(8'h55, 1'b0, 80, -1, -1, v78, v79);
        rx_i = 1'b0;
        idle(20);
        check("break_busy", busy_o, 1'b1);
        rx_i = 1'b1;
        idle(6);
        check("break_idle", busy_o, 1'b0);
        check("ferr_pulses", fe_cnt, 1);
        send(8'h40);
        send(8'h49);
        idle(3);
        check("ferr_count", got.size(), 1);
        check("ferr_word", first_word(), 16'h4049);

        // Backpressure and overrun
        got.delete();
        ov_cnt = 0;
        word_ready_i = 1'b0;
        send(8'h3F);
        send(8'h80);
        send(8'h40);
        send(8'h00);
        idle(2);
        check("bp_word", word_o, 16'h3F80);
        check("bp_valid", word_valid_o, 1'b1);
        check("bp_ovr", ov_cnt, 1);
        check("bp_none", got.size(), 0);
        word_ready_i = 1'b1;
        @(negedge clk);
        word_ready_i = 1'b0;
        #3;
        check("bp_drop", word_valid_o, 1'b0);
        check("bp_acc", first_word(), 16'h3F80);

        // Ready aligned with the completion edge: swap without overrun
        got.delete();
        ov_cnt = 0;
        send(8'h3F);
        send(8'h80);
        send(8'h40);
        drive_frame(8'h00, 1'b1, 80, 78, -1, v78, v79);
        idle(2);
        check("al_word", word_o, 16'h4000);
        check("al_valid", word_valid_o, 1'b1);
        check("al_ovr", ov_cnt, 0);
        check("al_acc", first_word(), 16'h3F80);
        word_ready_i = 1'b1;
        idle(1);
        word_ready_i = 1'b0;
        idle(2);

        // Reset during data bit 4 of the second byte of a half-word
        send(8'h11);
        send(8'h22);
        send(8'h12);
        drive_frame(8'h34, 1'b1, 46, -1, 44, v78, v79);
        idle(5);
        check("mrst_valid", word_valid_o, 1'b0);
        check("mrst_word", word_o, 16'h0000);
        check("mrst_busy", busy_o, 1'b0);
        got.delete();
        word_ready_i = 1'b1;
        send(8'hC0);
        send(8'h00);
        idle(3);
        check("mrst_count", got.size(), 1);
        check("mrst_next", first_word(), 16'hC000);

        // Random bytes, random gaps; model pairs consecutive bytes
        got.delete();
        ov_cnt = 0;
        fe_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            rb.push_back(8'($urandom_range(0, 255)));
            send(rb[i]);
            idle(int'($urandom_range(0, 12)));
        end
        idle(4);
        check("rand_count", got.size(), rb.size() / 2);
        for (int k = 0; k < rb.size() / 2; k++) begin
            check("rand_word", (k < got.size()) ? got[k] : 16'hxxxx,
                  {rb[2*k], rb[2*k+1]});
        end
        check("rand_ovr", ov_cnt, 0);
        check("rand_ferr", fe_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
